// File: rtl/bp_fe_bht_access_sched.sv
//------------------------------------------------------------------------------
// Module   : bp_fe_bht_access_sched
// Purpose  : Merges prediction reads and buffered updates onto one BHT port,
//            reads first, with a forced drain that bounds update starvation.
// Options  : BP_FE_BHT_SCHED_STATS_EN adds read/write/forced-drain counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bp_fe_bht_access_sched #(
  parameter int bht_idx_width_p = 9,
  parameter int fifo_els_p      = 4,
  parameter int starve_limit_p  = 3
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       rd_v_i,
  input  logic [bht_idx_width_p-1:0] rd_idx_i,
  output logic                       rd_ready_o,
  output logic                       pred_v_o,
  output logic                       predict_o,
  input  logic                       upd_v_i,
  input  logic [bht_idx_width_p-1:0] upd_idx_i,
  input  logic                       upd_correct_i,
  output logic                       upd_ready_o,
  input  logic                       flush_i,
  output logic                       bp_r_v_o,
  output logic [bht_idx_width_p-1:0] bp_idx_r_o,
  output logic                       bp_w_v_o,
  output logic [bht_idx_width_p-1:0] bp_idx_w_o,
  output logic                       bp_correct_o,
`ifdef BP_FE_BHT_SCHED_STATS_EN
  output logic [31:0]                stat_rd_cnt_o,
  output logic [31:0]                stat_wr_cnt_o,
  output logic [31:0]                stat_force_cnt_o,
`endif
  input  logic                       bp_predict_i
);

  localparam int ptr_w_lp = $clog2(fifo_els_p);
  localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(starve_limit_p - 1);
  localparam logic [ptr_w_lp:0]   ptr_one_lp  = (ptr_w_lp + 1)'(1);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                      state;
  logic [cnt_w_lp-1:0]         starve_cnt;
  logic [ptr_w_lp:0]           wptr;
  logic [ptr_w_lp:0]           rptr;
  logic [bht_idx_width_p:0]    mem [fifo_els_p];
  logic [bht_idx_width_p:0]    head;

  logic empty;
  logic full;
  logic rd_grant;
  logic deq;
  logic enq;
  logic drain_go;

  // The extra MSB separates full (MSBs differ) from empty (MSBs equal).
  assign empty = (wptr == rptr);
  assign full  = (wptr[ptr_w_lp] != rptr[ptr_w_lp]) &&
                 (wptr[ptr_w_lp-1:0] == rptr[ptr_w_lp-1:0]);
  assign head  = mem[rptr[ptr_w_lp-1:0]];

  assign upd_ready_o = !full && !flush_i;
  assign enq         = upd_v_i && upd_ready_o && !reset_i;
  assign rd_grant    = !reset_i && (state == RUN) && rd_v_i;
  assign deq         = !reset_i && !flush_i && !empty && ((state == DRAIN) || !rd_v_i);
  assign drain_go    = rd_grant && !empty && !flush_i && (starve_cnt == cnt_last_lp);

  assign rd_ready_o   = rd_grant;
  assign bp_r_v_o     = rd_grant;
  assign bp_idx_r_o   = rd_idx_i;
  assign bp_w_v_o     = deq;
  assign bp_idx_w_o   = head[bht_idx_width_p:1];
  assign bp_correct_o = head[0];
  assign predict_o    = pred_v_o && bp_predict_i;

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wptr[ptr_w_lp-1:0]] <= {upd_idx_i, upd_correct_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= RUN;
      starve_cnt <= '0;
      wptr       <= '0;
      rptr       <= '0;
      pred_v_o   <= 1'b0;
    end else begin
      pred_v_o <= bp_r_v_o;
      if (flush_i) begin
        rptr       <= wptr;
        starve_cnt <= '0;
        state      <= RUN;
      end else begin
        if (enq) wptr <= wptr + ptr_one_lp;
        if (deq) rptr <= rptr + ptr_one_lp;
        if (state == DRAIN) begin
          state      <= RUN;
          starve_cnt <= '0;
        end else if (rd_grant && !empty) begin
          // Counter reaching the limit on this edge makes the next cycle a drain.
          starve_cnt <= starve_cnt + cnt_one_lp;
          if (drain_go) state <= DRAIN;
        end else begin
          starve_cnt <= '0;
        end
      end
    end
  end

`ifdef BP_FE_BHT_SCHED_STATS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_rd_cnt_o    <= '0;
      stat_wr_cnt_o    <= '0;
      stat_force_cnt_o <= '0;
    end else begin
      if (rd_grant) stat_rd_cnt_o    <= stat_rd_cnt_o + 32'd1;
      if (deq)      stat_wr_cnt_o    <= stat_wr_cnt_o + 32'd1;
      if (drain_go) stat_force_cnt_o <= stat_force_cnt_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
